fpu_seq: RTL and testbench



---
 rtl/fpu_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_fpu_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fpu_seq.sv
// fpu_seq: multi-cycle IEEE-754 add/sub/compare/mov unit for the COP1 path.
// Subnormal inputs flush to zero, results round to nearest-even, no subnormal outputs.
module fpu_seq #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cc,
    output logic [3:0]   flags
);
    localparam int MW  = MAN_W + 4;   // hidden + fraction + G/R/S
    localparam int SW  = MAN_W + 5;   // MW plus carry-out
    localparam int EW  = EXP_W + 2;   // two's-complement working exponent
    localparam int LZW = $clog2(MW + 1);
    localparam logic [EW-1:0] EALL = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND} state_t;
    state_t state;
    logic   arith;

    function automatic logic [LZW-1:0] lzc(input logic [MW-1:0] v);
        logic [LZW-1:0] n;
        logic           hit;
        n   = '0;
        hit = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            hit = hit | v[i];
            if (!hit) n = n + LZW'(1);
        end
        return n;
    endfunction

    // Input decode, shared by the compare/mov retire and the add/sub capture
    logic [EXP_W-1:0] ea_in, eb_in;
    logic             zero_a, zero_b, nan_a, nan_b, inf_a, inf_b, sb_in, inv_in;
    logic [W-2:0]     mag_a, mag_b;
    logic             eq, lt, cmp;
    logic [W-1:0]     sp_in;

    assign ea_in  = a[W-2:MAN_W];
    assign eb_in  = b[W-2:MAN_W];
    assign zero_a = ~|ea_in;
    assign zero_b = ~|eb_in;
    assign nan_a  = (&ea_in) & (|a[MAN_W-1:0]);
    assign nan_b  = (&eb_in) & (|b[MAN_W-1:0]);
    assign inf_a  = (&ea_in) & ~(|a[MAN_W-1:0]);
    assign inf_b  = (&eb_in) & ~(|b[MAN_W-1:0]);
    assign sb_in  = b[W-1] ^ op[0];
    assign inv_in = nan_a | nan_b | (inf_a & inf_b & (a[W-1] ^ sb_in));
    assign mag_a  = zero_a ? '0 : a[W-2:0];
    assign mag_b  = zero_b ? '0 : b[W-2:0];
    assign eq     = (mag_a == mag_b) && ((a[W-1] == b[W-1]) || (mag_a == '0));
    assign lt     = !eq && ((a[W-1] != b[W-1]) ? a[W-1]
                                               : (a[W-1] ? (mag_a > mag_b) : (mag_a < mag_b)));

    always_comb begin
        case (op)
            3'b010:  cmp = eq;
            3'b011:  cmp = lt | eq;
            3'b100:  cmp = lt;
            3'b101:  cmp = ~lt;
            default: cmp = ~(lt | eq);
        endcase
        if (nan_a | nan_b) cmp = 1'b0;
    end

    always_comb begin
        if (inv_in)     sp_in = QNAN;
        else if (inf_a) sp_in = {a[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else            sp_in = {sb_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    // Pipeline registers; each stage reloads every cycle from the one before
    logic             sa, sb, sp, sp_inv;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    logic [W-1:0]     sp_val;
    logic             sx_r, sub_r, ss_r, ns_r, nz_r;
    logic [EXP_W-1:0] ex_r, es_r;
    logic [MW-1:0]    mx_r, my_r, nm_r;
    logic [SW-1:0]    sum_r;
    logic [EW-1:0]    ne_r;

    // Align: the smaller magnitude shifts right, losing bits into sticky
    logic             a_big;
    logic [EXP_W-1:0] ex, ey, diff;
    logic [MAN_W:0]   mx, my;
    logic [MW-1:0]    sh_hi, sh_lo, my_al;

    assign a_big          = {ea, ma} >= {eb, mb};
    assign ex             = a_big ? ea : eb;
    assign ey             = a_big ? eb : ea;
    assign mx             = a_big ? ma : mb;
    assign my             = a_big ? mb : ma;
    assign diff           = ex - ey;
    assign {sh_hi, sh_lo} = {my, 3'b000, {MW{1'b0}}} >> diff;
    assign my_al          = (int'(diff) >= MAN_W + 3) ? {{(MW-1){1'b0}}, |my}
                                                      : {sh_hi[MW-1:1], sh_hi[0] | (|sh_lo)};

    logic [SW-1:0] sum;
    assign sum = sub_r ? ({1'b0, mx_r} - {1'b0, my_r}) : ({1'b0, mx_r} + {1'b0, my_r});

    logic [LZW-1:0] lz;
    logic [MW-1:0]  nm;
    logic [EW-1:0]  ne;
    assign lz = lzc(sum_r[MW-1:0]);

    always_comb begin
        if (sum_r[SW-1]) begin
            nm = {sum_r[SW-1:2], sum_r[1] | sum_r[0]};
            ne = {2'b00, es_r} + EW'(1);
        end else begin
            nm = sum_r[MW-1:0] << lz;
            ne = {2'b00, es_r} - EW'(lz);
        end
    end

    logic             up, inexact;
    logic [MAN_W+1:0] rm;
    logic [EW-1:0]    re;
    logic [MAN_W-1:0] frac;
    logic [W-1:0]     rnd_res;
    logic [3:0]       rnd_fl;

    assign inexact = |nm_r[2:0];
    assign up      = nm_r[2] & (nm_r[1] | nm_r[0] | nm_r[3]);
    assign rm      = {1'b0, nm_r[MW-1:3]} + (MAN_W+2)'(up);
    assign re      = rm[MAN_W+1] ? ne_r + EW'(1) : ne_r;
    assign frac    = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];

    always_comb begin
        rnd_res = {ns_r, re[EXP_W-1:0], frac};
        rnd_fl  = {3'b000, inexact};
        if (sp) begin
            rnd_res = sp_val;
            rnd_fl  = {sp_inv, 3'b000};
        end else if (nz_r) begin
            rnd_res = {ns_r, {(W-1){1'b0}}};
            rnd_fl  = 4'b0000;
        end else if ($signed(re) >= $signed(EALL)) begin
            rnd_res = {ns_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_fl  = 4'b0101;
        end else if (re[EW-1] || re == '0) begin
            rnd_res = {ns_r, {(W-1){1'b0}}};
            rnd_fl  = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            sa     <= a[W-1];
            sb     <= sb_in;
            ea     <= ea_in;
            eb     <= eb_in;
            ma     <= zero_a ? '0 : {1'b1, a[MAN_W-1:0]};
            mb     <= zero_b ? '0 : {1'b1, b[MAN_W-1:0]};
            sp     <= nan_a | nan_b | inf_a | inf_b;
            sp_inv <= inv_in;
            sp_val <= sp_in;
        end
        sx_r  <= a_big ? sa : sb;
        sub_r <= sa ^ sb;
        ex_r  <= ex;
        mx_r  <= {mx, 3'b000};
        my_r  <= my_al;
        sum_r <= sum;
        es_r  <= ex_r;
        ss_r  <= (sum == '0 && sub_r) ? 1'b0 : sx_r;
        nm_r  <= nm;
        ne_r  <= ne;
        ns_r  <= ss_r;
        nz_r  <= (sum_r == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            arith  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cc     <= 1'b0;
            flags  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= UNPACK;
                    busy  <= 1'b1;
                    arith <= ~op[2] & ~op[1];
                    if (op == 3'b111) begin
                        result <= b;
                        flags  <= '0;
                        done   <= 1'b1;
                    end else if (op[2] | op[1]) begin
                        cc    <= cmp;
                        flags <= {nan_a | nan_b, 3'b000};
                        done  <= 1'b1;
                    end
                end
                UNPACK: begin
                    state <= arith ? ALIGN : IDLE;
                    busy  <= arith;
                end
                ALIGN:  state <= ADDSUB;
                ADDSUB: state <= NORM;
                NORM: begin
                    state  <= ROUND;
                    done   <= 1'b1;
                    result <= rnd_res;
                    flags  <= rnd_fl;
                end
                ROUND: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq: binary32 instance plus a binary16 instance.
module tb_fpu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0, result;
    logic        busy, done, cc;
    logic [3:0]  flags;
    logic        start16 = 1'b0;
    logic [2:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0, result16;
    logic        busy16, done16, cc16;
    logic [3:0]  flags16;
    int          checks = 0, errors = 0, lat, ndone;

    always #5 clk = ~clk;

    fpu_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cc(cc), .flags(flags)
    );

    fpu_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .cc(cc16), .flags(flags16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int exp_lat, input logic [31:0] exp_res,
                       input logic [3:0] exp_fl, input logic exp_cc);
        issue(o, x, y);
        chk({tag, " lat"}, lat, exp_lat);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " res"}, result, exp_res);
        chk({tag, " flags"}, flags, exp_fl);
        chk({tag, " cc"}, cc, exp_cc);
        @(negedge clk);
        chk({tag, " idle"}, {busy, done}, 0);
    endtask

    task automatic run16(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] exp_res, input logic [3:0] exp_fl);
        @(negedge clk);
        start16 = 1'b1; op16 = 3'd0; a16 = x; b16 = y;
        @(negedge clk);
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " lat"}, lat, 5);
        chk({tag, " res"}, result16, exp_res);
        chk({tag, " flags"}, flags16, exp_fl);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst result", result, 0);
        chk("rst cc", cc, 0);
        chk("rst flags", flags, 0);
        chk("rst busy/done", {busy, done}, 0);
        chk("rst16 result", result16, 0);
        rst = 1'b0;

        // basic add with per-cycle busy/done profile
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'h3F800000; b = 32'h40000000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("add1 busy/done", {busy, done}, k <= 4 ? 2'b10 : (k == 5 ? 2'b11 : 2'b00));
        end
        chk("add1 res", result, 32'h40400000);
        chk("add1 flags", flags, 0);

        run("tie",      3'd0, 32'h4B800000, 32'h3F800000, 5, 32'h4B800000, 4'b0001, 1'b0);
        run("ovf",      3'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5, 32'h7F800000, 4'b0101, 1'b0);
        run("sub0",     3'd1, 32'h3F800000, 32'h3F800000, 5, 32'h00000000, 4'b0000, 1'b0);
        run("sticky",   3'd0, 32'h3F800000, 32'hB3800000, 5, 32'h3F7FFFFF, 4'b0000, 1'b0);
        run("tie sub",  3'd0, 32'h3F800000, 32'hB3000000, 5, 32'h3F800000, 4'b0001, 1'b0);
        run("unf",      3'd1, 32'h00800000, 32'h00800001, 5, 32'h80000000, 4'b0011, 1'b0);
        run("flush",    3'd0, 32'h00000001, 32'h3F800000, 5, 32'h3F800000, 4'b0000, 1'b0);
        run("ceq zero", 3'd2, 32'h80000000, 32'h00000000, 1, 32'h3F800000, 4'b0000, 1'b1);
        run("clt zero", 3'd4, 32'h80000000, 32'h00000000, 1, 32'h3F800000, 4'b0000, 1'b0);
        run("cle zero", 3'd3, 32'h80000000, 32'h00000000, 1, 32'h3F800000, 4'b0000, 1'b1);
        run("cge neg",  3'd5, 32'hBF800000, 32'h3F800000, 1, 32'h3F800000, 4'b0000, 1'b0);
        run("cgt",      3'd6, 32'h40000000, 32'h3F800000, 1, 32'h3F800000, 4'b0000, 1'b1);
        run("clt nan",  3'd4, 32'h7FC00000, 32'h3F800000, 1, 32'h3F800000, 4'b1000, 1'b0);
        run("inf-inf",  3'd1, 32'h7F800000, 32'h7F800000, 5, 32'h7FC00000, 4'b1000, 1'b0);
        run("mov",      3'd7, 32'h00000000, 32'h7F800001, 1, 32'h7F800001, 4'b0000, 1'b0);
        run("ninf+1",   3'd0, 32'hFF800000, 32'h3F800000, 5, 32'hFF800000, 4'b0000, 1'b0);
        run("n0+n0",    3'd0, 32'h80000000, 32'h80000000, 5, 32'h80000000, 4'b0000, 1'b0);

        // start while busy is dropped
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'h3F800000; b = 32'h40000000;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == 2);
            op    = (k == 2) ? 3'd7 : 3'd0;
            b     = 32'h12345678;
            if (done) ndone++;
        end
        chk("busy start dones", ndone, 1);
        chk("busy start res", result, 32'h40400000);

        // start in the done cycle is dropped; next cycle accepts
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'h3F800000; b = 32'h3F800000;
        @(negedge clk);
        chk("sd cmp done/cc", {done, cc}, 2'b11);
        op = 3'd7; b = 32'hAAAA5555;
        @(negedge clk);
        chk("sd ignored", {busy, done}, 2'b00);
        @(negedge clk);
        start = 1'b0;
        chk("sd mov done", done, 1);
        chk("sd mov res", result, 32'hAAAA5555);
        @(negedge clk);

        // reset in the middle of an add
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'h3F800000; b = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy/done", {busy, done}, 0);
        chk("abort result", result, 0);
        chk("abort flags", flags, 0);
        chk("abort cc", cc, 0);
        ndone = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort dones", ndone, 0);

        run16("h 1+1",   16'h3C00, 16'h3C00, 16'h4000, 4'b0000);
        run16("h 1+.5",  16'h3C00, 16'h3800, 16'h3E00, 4'b0000);
        run16("h ovf",   16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
